mel_seq: RTL and testbench

//  Sequencer for the mel-filterbank accumulator (addmel) in the MFCC chain.
//  On start, walks mel filters 0..N_MEL-1. Per filter it reads FFT-energy bins
//  mel_lo..mel_hi and drives addmel_new/enable/addmel_sel so addmel sums them.
//  It then strobes the finished sum into the mel register file.

---
 rtl/mel_seq.sv | 195 +++++++++++++++++++
 tb/tb_mel_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mel_seq.sv
// mel_seq: sequencer for the mel-filterbank accumulator (addmel) in the MFCC chain.
// On start, walks mel filters 0..N_MEL-1. For each filter it issues regffte reads
// for bins mel_lo..mel_hi. With acc_mode it adds one extra slot that reads
// regmel[mel_idx]. A tag travels with every slot through an RD_LAT-deep pipeline, so
// the addmel controls line up with the memory data. The finished sum is strobed into
// regmel one cycle after the last tagged slot reaches addmel.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, acc_mode        frame start pulse; accumulate mode (sampled at start)
//   mel_idx                filter index to the boundary ROM and regmel read address
//   mel_lo, mel_hi         boundary ROM data for mel_idx
//   ffte_addr, ffte_rd     regffte read port
//   addmel_new, enable     addmel load-first / accumulate controls
//   addmel_sel             addmel operand select (0 regffte, 1 regmel)
//   mel_we, mel_waddr      regmel write port
//   busy, done             frame in progress; 1-cycle completion pulse
module mel_seq #(
   parameter int unsigned N_MEL  = 26,
   parameter int unsigned BIN_W  = 9,
   parameter int unsigned MEL_W  = 5,
   parameter int unsigned RD_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             acc_mode,
   output logic [MEL_W-1:0] mel_idx,
   input  logic [BIN_W-1:0] mel_lo,
   input  logic [BIN_W-1:0] mel_hi,
   output logic [BIN_W-1:0] ffte_addr,
   output logic             ffte_rd,
   output logic             addmel_new,
   output logic             enable,
   output logic             addmel_sel,
   output logic             mel_we,
   output logic [MEL_W-1:0] mel_waddr,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CNT_W = $clog2(RD_LAT + 1) + 1;

   typedef enum logic [1:0] {StIdle, StIssue, StMerge, StDrain} state_e;

   typedef struct packed {
      logic             vld;
      logic             first;
      logic             merge;
      logic             last;
      logic [MEL_W-1:0] idx;
   } tag_t;

   state_e                  state_q, state_d;
   logic                    acc_q, acc_d;
   logic                    first_q, first_d;
   logic [BIN_W-1:0]        bin_q, bin_d;
   logic [MEL_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    done_q, done_d;
   logic                    we_q;
   logic [MEL_W-1:0]        waddr_q;
   tag_t [RD_LAT-1:0]       tag_q;
   tag_t                    slot;
   tag_t                    tag_at;

   logic [BIN_W-1:0]        addr;
   logic [BIN_W-1:0]        hi_eff;
   logic                    last_bin;
   logic                    last_filter;

   // The first bin of a filter comes straight from the ROM, because mel_idx has only
   // just advanced and bin_q cannot hold the new filter's mel_lo yet.
   assign addr        = first_q ? mel_lo : bin_q;
   assign hi_eff      = (mel_hi < mel_lo) ? mel_lo : mel_hi;
   assign last_bin    = (addr == hi_eff);
   assign last_filter = (idx_q == MEL_W'(N_MEL - 1));

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      first_d   = first_q;
      bin_d     = bin_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      ffte_rd   = 1'b0;
      ffte_addr = '0;
      slot      = '0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StIssue;
               acc_d   = acc_mode;
               first_d = 1'b1;
               idx_d   = '0;
            end
         end
         StIssue: begin
            ffte_rd    = 1'b1;
            ffte_addr  = addr;
            slot.vld   = 1'b1;
            slot.first = first_q;
            slot.last  = last_bin & ~acc_q;
            slot.idx   = idx_q;
            first_d    = 1'b0;
            bin_d      = addr + 1'b1;
            if (last_bin) begin
               if (acc_q) begin
                  state_d = StMerge;
               end else if (last_filter) begin
                  state_d = StDrain;
                  cnt_d   = '0;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  first_d = 1'b1;
               end
            end
         end
         StMerge: begin
            // regmel is read at mel_idx; this slot adds it to the running sum.
            slot.vld   = 1'b1;
            slot.merge = 1'b1;
            slot.last  = 1'b1;
            slot.idx   = idx_q;
            if (last_filter) begin
               state_d = StDrain;
               cnt_d   = '0;
            end else begin
               state_d = StIssue;
               idx_d   = idx_q + 1'b1;
               first_d = 1'b1;
            end
         end
         StDrain: begin
            if (cnt_q == CNT_W'(RD_LAT)) begin
               state_d = StIdle;
               done_d  = 1'b1;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         acc_q   <= 1'b0;
         first_q <= 1'b0;
         bin_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         first_q <= first_d;
         bin_q   <= bin_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Tag delay line: stage RD_LAT-1 coincides with the memory data at addmel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
      end else begin
         tag_q[0] <= slot;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            tag_q[i] <= tag_q[i-1];
         end
         // addmel registers its sum, so the write trails the last slot by one cycle.
         we_q    <= tag_at.vld & tag_at.last;
         waddr_q <= (tag_at.vld & tag_at.last) ? tag_at.idx : '0;
      end
   end

   assign tag_at     = tag_q[RD_LAT-1];
   assign addmel_new = tag_at.vld & tag_at.first;
   assign enable     = tag_at.vld & ~tag_at.first;
   assign addmel_sel = tag_at.vld & tag_at.merge;
   assign mel_we     = we_q;
   assign mel_waddr  = waddr_q;
   assign mel_idx    = idx_q;
   assign busy       = (state_q != StIdle);
   assign done       = done_q;

endmodule

// File: tb/tb_mel_seq.sv
// Bench for mel_seq: two instances (RD_LAT 1 and 2) share a boundary ROM, an energy
// memory, a regmel memory and an addmel model; only one instance runs at a time.
module tb_mel_seq;

   localparam int unsigned N_MEL = 4;
   localparam int unsigned BIN_W = 9;
   localparam int unsigned MEL_W = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic start_a = 1'b0, start_b = 1'b0, acc_mode = 1'b0;
   logic [MEL_W-1:0] mel_idx_a, mel_idx_b, mel_waddr_a, mel_waddr_b;
   logic [BIN_W-1:0] mel_lo_a, mel_hi_a, mel_lo_b, mel_hi_b, ffte_addr_a, ffte_addr_b;
   logic ffte_rd_a, addmel_new_a, enable_a, addmel_sel_a, mel_we_a, busy_a, done_a;
   logic ffte_rd_b, addmel_new_b, enable_b, addmel_sel_b, mel_we_b, busy_b, done_b;

   mel_seq #(.N_MEL(N_MEL), .BIN_W(BIN_W), .MEL_W(MEL_W), .RD_LAT(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .acc_mode(acc_mode),
      .mel_idx(mel_idx_a), .mel_lo(mel_lo_a), .mel_hi(mel_hi_a),
      .ffte_addr(ffte_addr_a), .ffte_rd(ffte_rd_a), .addmel_new(addmel_new_a),
      .enable(enable_a), .addmel_sel(addmel_sel_a), .mel_we(mel_we_a),
      .mel_waddr(mel_waddr_a), .busy(busy_a), .done(done_a)
   );

   mel_seq #(.N_MEL(N_MEL), .BIN_W(BIN_W), .MEL_W(MEL_W), .RD_LAT(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .acc_mode(acc_mode),
      .mel_idx(mel_idx_b), .mel_lo(mel_lo_b), .mel_hi(mel_hi_b),
      .ffte_addr(ffte_addr_b), .ffte_rd(ffte_rd_b), .addmel_new(addmel_new_b),
      .enable(enable_b), .addmel_sel(addmel_sel_b), .mel_we(mel_we_b),
      .mel_waddr(mel_waddr_b), .busy(busy_b), .done(done_b)
   );

   // Environment: ROM, memories, addmel
   logic [BIN_W-1:0] lo_tab [N_MEL];
   logic [BIN_W-1:0] hi_tab [N_MEL];
   logic [15:0]      energy [512];
   int               regmel [N_MEL];
   int               preload [N_MEL];
   logic             do_preload = 1'b0;
   int               sel_u = 0;
   int               errors = 0;
   int               checks = 0;

   always_comb begin
      mel_lo_a = (mel_idx_a < N_MEL) ? lo_tab[mel_idx_a] : '0;
      mel_hi_a = (mel_idx_a < N_MEL) ? hi_tab[mel_idx_a] : '0;
      mel_lo_b = (mel_idx_b < N_MEL) ? lo_tab[mel_idx_b] : '0;
      mel_hi_b = (mel_idx_b < N_MEL) ? hi_tab[mel_idx_b] : '0;
   end

   logic [BIN_W-1:0] m_addr;
   logic [MEL_W-1:0] m_idx, m_waddr;
   logic             m_new, m_en, m_sel, m_we;
   int               fd1, fd2, md1, md2, f_out, r_out, sum_q;

   always_comb begin
      m_addr  = (sel_u == 0) ? ffte_addr_a  : ffte_addr_b;
      m_idx   = (sel_u == 0) ? mel_idx_a    : mel_idx_b;
      m_waddr = (sel_u == 0) ? mel_waddr_a  : mel_waddr_b;
      m_new   = (sel_u == 0) ? addmel_new_a : addmel_new_b;
      m_en    = (sel_u == 0) ? enable_a     : enable_b;
      m_sel   = (sel_u == 0) ? addmel_sel_a : addmel_sel_b;
      m_we    = (sel_u == 0) ? mel_we_a     : mel_we_b;
      f_out   = (sel_u == 0) ? fd1 : fd2;
      r_out   = (sel_u == 0) ? md1 : md2;
   end

   always @(posedge clk) begin
      fd1 <= int'(energy[m_addr]);
      fd2 <= fd1;
      md1 <= (m_idx < N_MEL) ? regmel[m_idx] : 0;
      md2 <= md1;
      if (m_new) sum_q <= f_out;
      else if (m_en) sum_q <= sum_q + (m_sel ? r_out : f_out);
      if (do_preload) begin
         for (int m = 0; m < N_MEL; m++) regmel[m] <= preload[m];
      end else if (m_we && m_waddr < N_MEL) begin
         regmel[m_waddr] <= sum_q;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] outs_a();
      return {6'b0, mel_idx_a, ffte_addr_a, ffte_rd_a, addmel_new_a, enable_a,
              addmel_sel_a, mel_we_a, mel_waddr_a, busy_a, done_a};
   endfunction

   function automatic logic [31:0] outs_b();
      return {6'b0, mel_idx_b, ffte_addr_b, ffte_rd_b, addmel_new_b, enable_b,
              addmel_sel_b, mel_we_b, mel_waddr_b, busy_b, done_b};
   endfunction

   task automatic load_regmel(input int v0, input int v1, input int v2, input int v3);
      preload[0] = v0; preload[1] = v1; preload[2] = v2; preload[3] = v3;
      @(posedge clk); #1 do_preload = 1'b1;
      @(posedge clk); #1 do_preload = 1'b0;
   endtask

   task automatic set_directed();
      lo_tab[0] = 3;  hi_tab[0] = 5;
      lo_tab[1] = 5;  hi_tab[1] = 6;
      lo_tab[2] = 7;  hi_tab[2] = 4;    // degenerate: one bin
      lo_tab[3] = 10; hi_tab[3] = 12;
      for (int b = 0; b < 512; b++) energy[b] = 16'(b);
   endtask

   task automatic set_random();
      int lo;
      for (int m = 0; m < N_MEL; m++) begin
         lo = $urandom_range(0, 500);
         lo_tab[m] = BIN_W'(lo);
         if ($urandom_range(0, 4) == 0) hi_tab[m] = BIN_W'($urandom_range(0, lo));
         else hi_tab[m] = BIN_W'(lo + $urandom_range(0, 6));
      end
      for (int b = 0; b < 512; b++) energy[b] = 16'($urandom_range(0, 65535));
   endtask

   // Runs one frame on instance u and checks it against a bin-list/sum model.
   task automatic run_frame(input int u, input bit acc, input bit extra);
      int lat, s, he, first_rd, first_new, sel_cnt, new_cnt, done_c, done_cnt;
      int last_we, bad, badw;
      int exp_sum [N_MEL];
      logic [BIN_W-1:0] exp_a[$], got_a[$];
      logic [MEL_W-1:0] got_w[$];
      logic rd, nw, en, sl, we, dn;
      logic [BIN_W-1:0] ad;
      logic [MEL_W-1:0] wa;
      lat = (u == 0) ? 1 : 2;
      sel_u = u;
      s = 0;
      for (int m = 0; m < N_MEL; m++) begin
         he = (hi_tab[m] < lo_tab[m]) ? int'(lo_tab[m]) : int'(hi_tab[m]);
         exp_sum[m] = acc ? regmel[m] : 0;
         for (int b = int'(lo_tab[m]); b <= he; b++) begin
            exp_a.push_back(BIN_W'(b));
            exp_sum[m] += int'(energy[b]);
         end
         s += he - int'(lo_tab[m]) + 1 + (acc ? 1 : 0);
      end
      first_rd = -1; first_new = -1; done_c = -1; last_we = -1;
      sel_cnt = 0; new_cnt = 0; done_cnt = 0;
      @(posedge clk); #1;
      acc_mode = acc;
      if (u == 0) start_a = 1'b1; else start_b = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      for (int c = 1; c < 2000; c++) begin
         @(negedge clk);
         rd = (u == 0) ? ffte_rd_a : ffte_rd_b;
         ad = (u == 0) ? ffte_addr_a : ffte_addr_b;
         nw = (u == 0) ? addmel_new_a : addmel_new_b;
         en = (u == 0) ? enable_a : enable_b;
         sl = (u == 0) ? addmel_sel_a : addmel_sel_b;
         we = (u == 0) ? mel_we_a : mel_we_b;
         wa = (u == 0) ? mel_waddr_a : mel_waddr_b;
         dn = (u == 0) ? done_a : done_b;
         if (rd) begin
            got_a.push_back(ad);
            if (first_rd < 0) first_rd = c;
         end
         if (nw) begin
            new_cnt++;
            if (first_new < 0) first_new = c;
         end
         if (en && sl) sel_cnt++;
         if (we) begin
            got_w.push_back(wa);
            last_we = c;
         end
         if (dn) begin
            done_cnt++;
            if (done_c < 0) done_c = c;
         end
         if (c == 1) acc_mode = ~acc;   // must already be latched
         if (extra && c == 2) begin
            if (u == 0) start_a = 1'b1; else start_b = 1'b1;
         end
         if (extra && c == 3) begin
            start_a = 1'b0; start_b = 1'b0;
         end
         if (done_c >= 0 && c >= done_c + 2) break;
      end
      chk("done_seen", 32'(done_c >= 0), 1);
      chk("frame_cycles", done_c, s + lat + 2);
      chk("rd_count", got_a.size(), exp_a.size());
      bad = 0;
      foreach (exp_a[i]) if (i >= got_a.size() || got_a[i] !== exp_a[i]) bad++;
      chk("rd_addrs_bad", bad, 0);
      chk("ctl_lag", first_new - first_rd, lat);
      chk("new_count", new_cnt, N_MEL);
      chk("sel_count", sel_cnt, acc ? N_MEL : 0);
      chk("we_count", got_w.size(), N_MEL);
      badw = 0;
      foreach (got_w[i]) if (int'(got_w[i]) != i) badw++;
      chk("waddr_bad", badw, 0);
      chk("done_after_we", done_c - last_we, 1);
      chk("done_pulses", done_cnt, 1);
      chk("busy_end", (u == 0) ? busy_a : busy_b, 0);
      for (int m = 0; m < N_MEL; m++) chk("regmel", regmel[m], exp_sum[m]);
   endtask

   initial begin
      int we_seen;
      set_directed();
      #12;
      chk("reset_outs_a", outs_a(), 0);
      chk("reset_outs_b", outs_b(), 0);
      rst_n = 1'b1;
      load_regmel(100, 200, 300, 400);

      // Directed frame, then explicit golden sums
      run_frame(0, 1'b0, 1'b0);
      chk("t3_golden", regmel[0], 12);
      chk("t4_degen", regmel[2], 7);
      load_regmel(100, 0, 0, 0);
      run_frame(0, 1'b1, 1'b0);
      chk("t3_acc", regmel[0], 112);

      // Reset in the middle of a frame
      sel_u = 0;
      @(posedge clk); #1 acc_mode = 1'b0; start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("t1_issuing", ffte_rd_a, 1);
      rst_n = 1'b0;
      #1;
      chk("t1_outs", outs_a(), 0);
      chk("t1_busy", busy_a, 0);
      we_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (mel_we_a) we_seen++;
      end
      chk("t1_no_we", we_seen, 0);
      rst_n = 1'b1;
      run_frame(0, 1'b0, 1'b0);

      // Start while busy, then random frames
      set_random();
      run_frame(0, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         set_random();
         load_regmel($urandom_range(0, 9999), $urandom_range(0, 9999),
                     $urandom_range(0, 9999), $urandom_range(0, 9999));
         run_frame(0, 1'($urandom_range(0, 1)), 1'(k == 2));
      end

      // Two-cycle read latency instance
      set_directed();
      run_frame(1, 1'b0, 1'b0);
      chk("t6_golden", regmel[0], 12);
      load_regmel(100, 0, 0, 0);
      run_frame(1, 1'b1, 1'b1);
      chk("t6_acc", regmel[0], 112);
      set_random();
      run_frame(1, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
